// File: rtl/matmul_tile_sequencer.sv
// Control sequencer for one NxN systolic matmul output tile: clear, K skewed operand reads, flush, row drain.
// Optional MATMUL_SEQ_PERF_EN adds saturating busy/stall cycle counters.
module matmul_tile_sequencer #(
   parameter int unsigned N     = 4,
   parameter int unsigned K_MAX = 64,
   parameter int unsigned AW    = $clog2(K_MAX),
   parameter int unsigned KW    = $clog2(K_MAX + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [KW-1:0]          k_len,
   output logic                   busy,
   output logic                   done,
   output logic                   arr_clear,
   output logic                   rd_en,
   output logic [AW-1:0]          rd_addr,
   output logic [N-1:0]           lane_vld,
   output logic                   out_valid,
   output logic [$clog2(N)-1:0]   drain_row,
   input  logic                   out_ready
`ifdef MATMUL_SEQ_PERF_EN
   ,
   output logic [31:0]            perf_busy_cyc,
   output logic [31:0]            perf_stall_cyc
`endif
);

   localparam int unsigned FW = $clog2(2 * N);
   localparam int unsigned CW = (KW > FW) ? KW : FW;
   localparam int unsigned RW = $clog2(N);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_FILL  = 3'd2,
      S_FLUSH = 3'd3,
      S_DRAIN = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic [KW-1:0]   r_k;
   logic [KW-1:0]   w_k_nxt;

   logic            r_busy;
   logic            r_done;
   logic            r_arr_clear;
   logic            r_rd_en;
   logic [AW-1:0]   r_rd_addr;
   logic [N-1:0]    r_lane;
   logic            r_out_valid;
   logic [RW-1:0]   r_drain_row;

   // Next-state and counter update; outputs are registered from the next-state view.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_k_nxt     = r_k;
      case (r_state)
         S_IDLE: begin
            if (start && (k_len != '0)) begin
               w_state_nxt = S_CLEAR;
               w_cnt_nxt   = '0;
               w_k_nxt     = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
            end
         end
         S_CLEAR: begin
            w_state_nxt = S_FILL;
            w_cnt_nxt   = '0;
         end
         S_FILL: begin
            if (r_cnt == (CW'(r_k) - CW'(1))) begin
               w_state_nxt = S_FLUSH;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         S_FLUSH: begin
            // Last flush cycle is the final MAC of the far-corner PE.
            if (r_cnt == CW'(2 * N - 2)) begin
               w_state_nxt = S_DRAIN;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         S_DRAIN: begin
            if (out_ready) begin
               if (r_cnt == CW'(N - 1)) begin
                  w_state_nxt = S_DONE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_k         <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_arr_clear <= 1'b0;
         r_rd_en     <= 1'b0;
         r_rd_addr   <= '0;
         r_lane      <= '0;
         r_out_valid <= 1'b0;
         r_drain_row <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_k         <= w_k_nxt;
         r_busy      <= (w_state_nxt == S_CLEAR) || (w_state_nxt == S_FILL) ||
                        (w_state_nxt == S_FLUSH) || (w_state_nxt == S_DRAIN);
         r_done      <= (w_state_nxt == S_DONE);
         r_arr_clear <= (w_state_nxt == S_CLEAR);
         r_rd_en     <= (w_state_nxt == S_FILL);
         r_rd_addr   <= (w_state_nxt == S_FILL) ? AW'(w_cnt_nxt) : '0;
         // Lane i sees the read strobe 1+i cycles late (1 for buffer latency, i for skew).
         r_lane      <= N'({r_lane, r_rd_en});
         r_out_valid <= (w_state_nxt == S_DRAIN);
         r_drain_row <= (w_state_nxt == S_DRAIN) ? RW'(w_cnt_nxt) : '0;
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign arr_clear = r_arr_clear;
   assign rd_en     = r_rd_en;
   assign rd_addr   = r_rd_addr;
   assign lane_vld  = r_lane;
   assign out_valid = r_out_valid;
   assign drain_row = r_drain_row;

`ifdef MATMUL_SEQ_PERF_EN
   logic        w_accept;
   logic [31:0] r_perf_busy;
   logic [31:0] r_perf_stall;

   assign w_accept = (r_state == S_IDLE) && start && (k_len != '0);

   // Saturating counters, cleared by reset or an accepted start.
   always_ff @(posedge clk) begin
      if (rst || w_accept) begin
         r_perf_busy  <= '0;
         r_perf_stall <= '0;
      end else begin
         if (r_busy && !(&r_perf_busy)) begin
            r_perf_busy <= r_perf_busy + 32'd1;
         end
         if (r_out_valid && !out_ready && !(&r_perf_stall)) begin
            r_perf_stall <= r_perf_stall + 32'd1;
         end
      end
   end

   assign perf_busy_cyc  = r_perf_busy;
   assign perf_stall_cyc = r_perf_stall;
`endif

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Scoreboard bench for matmul_tile_sequencer: stimulus pushes expected (cycle, value) events, a monitor pops them.
module tb_matmul_tile_sequencer;

   localparam int N  = 4;
   localparam int KW = 7;
   localparam int AW = 6;

   typedef struct {
      int cyc;
      int val;
   } ev_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [KW-1:0]   k_len;
   logic            busy;
   logic            done;
   logic            arr_clear;
   logic            rd_en;
   logic [AW-1:0]   rd_addr;
   logic [N-1:0]    lane_vld;
   logic            out_valid;
   logic [1:0]      drain_row;
   logic            out_ready = 1'b1;
`ifdef MATMUL_SEQ_PERF_EN
   logic [31:0]     perf_busy_cyc;
   logic [31:0]     perf_stall_cyc;
`endif

   matmul_tile_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .k_len     (k_len),
      .busy      (busy),
      .done      (done),
      .arr_clear (arr_clear),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .lane_vld  (lane_vld),
      .out_valid (out_valid),
      .drain_row (drain_row),
      .out_ready (out_ready)
`ifdef MATMUL_SEQ_PERF_EN
      ,
      .perf_busy_cyc  (perf_busy_cyc),
      .perf_stall_cyc (perf_stall_cyc)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int stall_lo = 1;
   int stall_hi = 0;
   always @(negedge clk) out_ready = !((cyc >= stall_lo) && (cyc <= stall_hi));

   int checks   = 0;
   int failures = 0;

   ev_t q_clr[$];
   ev_t q_rd[$];
   ev_t q_lane[$];
   ev_t q_busy[$];
   ev_t q_drain[$];
   ev_t q_done[$];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
      end
   endtask

   task automatic chk_ev(input string nm, input ev_t e, input int val);
      checks++;
      if ((e.cyc != cyc) || (e.val != val)) begin
         failures++;
         $display("FAIL %s: got value %0d at cycle %0d, expected value %0d at cycle %0d",
                  nm, val, cyc, e.val, e.cyc);
      end
   endtask

   task automatic unexpected(input string nm, input int val);
      checks++;
      failures++;
      $display("FAIL %s: unexpected assertion value %0d at cycle %0d", nm, val, cyc);
   endtask

   // Expected events for one tile sampled at cycle t0; events at or after cut are dropped.
   task automatic push_tile(input int t0, input int k, input int s, input int cut);
      int ds;
      int v;
      ds = t0 + k + 2 * N + 1;
      if (t0 + 1 < cut) q_clr.push_back('{t0 + 1, 1});
      for (int j = 0; j < k; j++)
         if (t0 + 2 + j < cut) q_rd.push_back('{t0 + 2 + j, j});
      for (int c = t0 + 3; c <= t0 + 2 + (N - 1) + k; c++) begin
         v = 0;
         for (int i = 0; i < N; i++)
            if ((c >= t0 + 3 + i) && (c <= t0 + 2 + i + k)) v = v | (1 << i);
         if (c < cut) q_lane.push_back('{c, v});
      end
      for (int c = t0 + 1; c <= ds + N - 1 + s; c++)
         if (c < cut) q_busy.push_back('{c, 1});
      for (int r = 0; r < N; r++) begin
         if (r < 2) begin
            if (ds + r < cut) q_drain.push_back('{ds + r, r});
         end else if (r == 2) begin
            for (int c = ds + 2; c <= ds + 2 + s; c++)
               if (c < cut) q_drain.push_back('{c, 2});
         end else begin
            if (ds + r + s < cut) q_drain.push_back('{ds + r + s, r});
         end
      end
      if (ds + N + s < cut) q_done.push_back('{ds + N + s, 1});
   endtask

   // Issue one tile (k within K_MAX) with s stall cycles while row 2 is presented, then wait it out.
   task automatic run_tile(input int k, input int s);
      int t0;
      int ds;
      @(negedge clk);
      start = 1'b1;
      k_len = KW'(k);
      t0    = cyc;
      ds    = t0 + k + 2 * N + 1;
      if (s > 0) begin
         stall_lo = ds + 2;
         stall_hi = ds + 1 + s;
      end else begin
         stall_lo = 1;
         stall_hi = 0;
      end
      push_tile(t0, k, s, 32'h3fff_ffff);
      @(negedge clk);
      start = 1'b0;
      repeat (k + 3 * N + s + 3) @(negedge clk);
   endtask

   // Monitor: pops an expected event for every cycle an output is presented.
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         #1;
         if (arr_clear === 1'b1) begin
            if (q_clr.size() == 0) unexpected("arr_clear", 1);
            else begin e = q_clr.pop_front(); chk_ev("arr_clear", e, 1); end
         end
         if (rd_en === 1'b1) begin
            if (q_rd.size() == 0) unexpected("rd_addr", int'(rd_addr));
            else begin e = q_rd.pop_front(); chk_ev("rd_addr", e, int'(rd_addr)); end
         end
         if ((lane_vld !== '0) && !$isunknown(lane_vld)) begin
            if (q_lane.size() == 0) unexpected("lane_vld", int'(lane_vld));
            else begin e = q_lane.pop_front(); chk_ev("lane_vld", e, int'(lane_vld)); end
         end
         if (busy === 1'b1) begin
            if (q_busy.size() == 0) unexpected("busy", 1);
            else begin e = q_busy.pop_front(); chk_ev("busy", e, 1); end
         end
         if (out_valid === 1'b1) begin
            if (q_drain.size() == 0) unexpected("drain_row", int'(drain_row));
            else begin e = q_drain.pop_front(); chk_ev("drain_row", e, int'(drain_row)); end
         end
         if (done === 1'b1) begin
            if (q_done.size() == 0) unexpected("done", 1);
            else begin e = q_done.pop_front(); chk_ev("done", e, 1); end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      int t0;
      int t1;
      rst   = 1'b1;
      start = 1'b0;
      k_len = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_ctrl", int'({arr_clear, rd_en, out_valid}), 0);
      chk("reset_addr_lane_row", int'({rd_addr, lane_vld, drain_row}), 0);
      @(negedge clk);
      rst = 1'b0;

      // Basic tile, k_len=3, no backpressure.
      run_tile(3, 0);

      // Backpressure on row 2 for 5 cycles.
      run_tile(3, 5);
`ifdef MATMUL_SEQ_PERF_EN
      #1;
      chk("perf_stall_cyc", int'(perf_stall_cyc), 5);
      chk("perf_busy_cyc", int'(perf_busy_cyc), 20);
`endif

      // k_len=0 is ignored.
      @(negedge clk);
      start = 1'b1;
      k_len = '0;
      repeat (3) @(negedge clk);
      #1;
      chk("klen0_busy", int'(busy), 0);
      chk("klen0_rd_en", int'(rd_en), 0);
      start = 1'b0;

      // start held with k_len=100: clamped to 64, restart only after DONE.
      @(negedge clk);
      start = 1'b1;
      k_len = KW'(100);
      t0    = cyc;
      t1    = t0 + 64 + 3 * N + 2;
      push_tile(t0, 64, 0, 32'h3fff_ffff);
      push_tile(t1, 64, 0, 32'h3fff_ffff);
      while (cyc < t1 + 1) @(negedge clk);
      start = 1'b0;
      repeat (64 + 3 * N + 3) @(negedge clk);

      // Reset during FILL at address 5 aborts the tile.
      @(negedge clk);
      start = 1'b1;
      k_len = KW'(10);
      t0    = cyc;
      push_tile(t0, 10, 0, t0 + 8);
      @(negedge clk);
      start = 1'b0;
      while (cyc < t0 + 7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_rd_en", int'(rd_en), 0);
      chk("abort_lane_vld", int'(lane_vld), 0);
      chk("abort_busy", int'(busy), 0);

      // Normal tile after the abort.
      run_tile(2, 0);

      repeat (5) @(negedge clk);
      chk("left_arr_clear", q_clr.size(), 0);
      chk("left_rd_addr", q_rd.size(), 0);
      chk("left_lane_vld", q_lane.size(), 0);
      chk("left_busy", q_busy.size(), 0);
      chk("left_drain_row", q_drain.size(), 0);
      chk("left_done", q_done.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
